// File: rtl/nn_loader_pkg.sv
// Shared types and word-count helpers for the stream loader.
// NN_LOADER_LABEL_EN adds a trailing label word to every sample.
package nn_loader_pkg;

   localparam int WORD_W = 64;

   typedef enum logic {
      MODE_WEIGHTS = 1'b0,
      MODE_SAMPLES = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      LOAD_S = 2'd2,
      DRAIN  = 2'd3
   } state_e;

   function automatic int hiddenWords(input int features, input int layers);
      return layers * (features + 1);
   endfunction

   function automatic int finalWords(input int layers);
      return layers + 1;
   endfunction

   function automatic int sampleWords(input int features);
`ifdef NN_LOADER_LABEL_EN
      return features + 1;
`else
      return features;
`endif
   endfunction

   // Index width that never collapses to zero bits for tiny configurations.
   function automatic int idxBits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nn_sample_pingpong.sv
// Double-buffered sample store: one buffer fills from the stream while the other is offered to the predictor.
// NN_LOADER_LABEL_EN adds per-buffer label storage.
module nn_sample_pingpong
   import nn_loader_pkg::*;
#(
   parameter int FEATURES = 15,
   parameter int WORD_W   = nn_loader_pkg::WORD_W,
   parameter int CNT_W    = 16,
   parameter int SW       = sampleWords(FEATURES),
   parameter int SIDX_W   = idxBits(SW)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wrEn_i,
   input  logic [SIDX_W-1:0]          wrIdx_i,
   input  logic [WORD_W-1:0]          wrData_i,
   input  logic                       wrLast_i,
   input  logic [CNT_W-1:0]           wrSmpIdx_i,
   output logic                       fillFull_o,
   output logic                       allEmptyNext_o,
   input  logic                       smp_ready_i,
   output logic                       smp_valid_o,
   output logic [FEATURES*WORD_W-1:0] smp_feat_o,
   output logic [WORD_W-1:0]          smp_label_o,
   output logic [CNT_W-1:0]           smp_index_o
);

   localparam int FEAT_AW = idxBits(FEATURES);

   logic [WORD_W-1:0] feat_q [2][FEATURES];
   logic [CNT_W-1:0]  idx_q [2];
   logic [1:0]        full_q, full_d;
   logic              fillPtr_q, fillPtr_d;
   logic              drainPtr_q, drainPtr_d;
   logic              drainFire;

   assign drainFire = full_q[drainPtr_q] && smp_ready_i;

   // Fill and drain always touch different buffers, so both may apply in one cycle.
   always_comb begin
      full_d     = full_q;
      fillPtr_d  = fillPtr_q;
      drainPtr_d = drainPtr_q;
      if (wrEn_i && wrLast_i) begin
         full_d[fillPtr_q] = 1'b1;
         fillPtr_d         = ~fillPtr_q;
      end
      if (drainFire) begin
         full_d[drainPtr_q] = 1'b0;
         drainPtr_d         = ~drainPtr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q     <= '0;
         fillPtr_q  <= 1'b0;
         drainPtr_q <= 1'b0;
         idx_q[0]   <= '0;
         idx_q[1]   <= '0;
      end else begin
         full_q     <= full_d;
         fillPtr_q  <= fillPtr_d;
         drainPtr_q <= drainPtr_d;
         if (wrEn_i && wrLast_i) begin
            idx_q[fillPtr_q] <= wrSmpIdx_i;
         end
      end
   end

`ifdef NN_LOADER_LABEL_EN
   logic [WORD_W-1:0] label_q [2];
`endif

   always_ff @(posedge clk) begin
      if (wrEn_i && !rst) begin
         if (int'(wrIdx_i) < FEATURES) begin
            feat_q[fillPtr_q][FEAT_AW'(wrIdx_i)] <= wrData_i;
         end
`ifdef NN_LOADER_LABEL_EN
         else begin
            label_q[fillPtr_q] <= wrData_i;
         end
`endif
      end
   end

   for (genvar f = 0; f < FEATURES; f++) begin : gFeat
      assign smp_feat_o[f*WORD_W +: WORD_W] = feat_q[drainPtr_q][f];
   end

`ifdef NN_LOADER_LABEL_EN
   assign smp_label_o = label_q[drainPtr_q];
`else
   assign smp_label_o = '0;
`endif

   assign smp_valid_o    = full_q[drainPtr_q];
   assign smp_index_o    = idx_q[drainPtr_q];
   assign fillFull_o     = full_q[fillPtr_q];
   assign allEmptyNext_o = ~|full_d;

endmodule

// File: rtl/nn_stream_loader.sv
// Sorts a stream of double words into weight banks and ping-pong sample buffers for the predictor.
// NN_LOADER_LABEL_EN selects samples with a trailing label word.
module nn_stream_loader
   import nn_loader_pkg::*;
#(
   parameter int FEATURES = 15,
   parameter int LAYERS   = 10,
   parameter int WORD_W   = nn_loader_pkg::WORD_W,
   parameter int CNT_W    = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               cfg_start,
   input  logic                               cfg_mode,
   input  logic [CNT_W-1:0]                   cfg_count,
   input  logic [WORD_W-1:0]                  s_data,
   input  logic                               s_valid,
   output logic                               s_ready,
   output logic                               busy,
   output logic                               done,
   output logic                               err,
   output logic                               weights_loaded,
   input  logic [idxBits(LAYERS)-1:0]         wt_rd_layer,
   input  logic [idxBits(FEATURES+1)-1:0]     wt_rd_idx,
   output logic [WORD_W-1:0]                  wt_rd_data,
   input  logic [idxBits(LAYERS+1)-1:0]       fw_rd_idx,
   output logic [WORD_W-1:0]                  fw_rd_data,
   output logic                               smp_valid,
   input  logic                               smp_ready,
   output logic [FEATURES*WORD_W-1:0]         smp_feat,
   output logic [WORD_W-1:0]                  smp_label,
   output logic [CNT_W-1:0]                   smp_index
);

   localparam int HID_WORDS = hiddenWords(FEATURES, LAYERS);
   localparam int FIN_WORDS = finalWords(LAYERS);
   localparam int TOTAL_W   = HID_WORDS + FIN_WORDS;
   localparam int SW        = sampleWords(FEATURES);
   localparam int WCNT_W    = idxBits(TOTAL_W);
   localparam int HA_W      = idxBits(HID_WORDS);
   localparam int FA_W      = idxBits(FIN_WORDS);
   localparam int SIDX_W    = idxBits(SW);
   localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(TOTAL_W - 1);
   localparam logic [SIDX_W-1:0] LAST_SWORD = SIDX_W'(SW - 1);

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wCnt_q, wCnt_d;
   logic [SIDX_W-1:0]   wordIdx_q, wordIdx_d;
   logic [CNT_W-1:0]    smpCnt_q, smpCnt_d;
   logic [CNT_W-1:0]    cfgCount_q, cfgCount_d;
   logic                wLoaded_q, wLoaded_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                sReady, wAccept, sAccept, sLast;
   logic                fillFull, allEmptyNext;

   logic [WORD_W-1:0]   hidW_q [HID_WORDS];
   logic [WORD_W-1:0]   finW_q [FIN_WORDS];
   logic [WORD_W-1:0]   wtRdData_q, fwRdData_q;
   logic [HA_W-1:0]     hidRdAddr;

   always_comb begin
      state_d    = state_q;
      wCnt_d     = wCnt_q;
      wordIdx_d  = wordIdx_q;
      smpCnt_d   = smpCnt_q;
      cfgCount_d = cfgCount_q;
      wLoaded_d  = wLoaded_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      sReady     = 1'b0;
      wAccept    = 1'b0;
      sAccept    = 1'b0;
      sLast      = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               if (mode_e'(cfg_mode) == MODE_WEIGHTS) begin
                  state_d   = LOAD_W;
                  wCnt_d    = '0;
                  wLoaded_d = 1'b0;
               end else if (!wLoaded_q) begin
                  err_d = 1'b1;
               end else if (cfg_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = LOAD_S;
                  cfgCount_d = cfg_count;
                  smpCnt_d   = '0;
                  wordIdx_d  = '0;
               end
            end
         end
         LOAD_W: begin
            sReady = 1'b1;
            if (s_valid) begin
               wAccept = 1'b1;
               if (wCnt_q == LAST_WORD) begin
                  state_d   = IDLE;
                  done_d    = 1'b1;
                  wLoaded_d = 1'b1;
                  wCnt_d    = '0;
               end else begin
                  wCnt_d = wCnt_q + WCNT_W'(1);
               end
            end
         end
         LOAD_S: begin
            sReady = !fillFull;
            if (s_valid && !fillFull) begin
               sAccept = 1'b1;
               if (wordIdx_q == LAST_SWORD) begin
                  sLast     = 1'b1;
                  wordIdx_d = '0;
                  smpCnt_d  = smpCnt_q + CNT_W'(1);
                  if ((smpCnt_q + CNT_W'(1)) == cfgCount_q) begin
                     state_d = DRAIN;
                  end
               end else begin
                  wordIdx_d = wordIdx_q + SIDX_W'(1);
               end
            end
         end
         DRAIN: begin
            // Finish on the drain itself so done lands the very next cycle.
            if (allEmptyNext) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wCnt_q     <= '0;
         wordIdx_q  <= '0;
         smpCnt_q   <= '0;
         cfgCount_q <= '0;
         wLoaded_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wCnt_q     <= wCnt_d;
         wordIdx_q  <= wordIdx_d;
         smpCnt_q   <= smpCnt_d;
         cfgCount_q <= cfgCount_d;
         wLoaded_q  <= wLoaded_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Weight storage survives reset; only the bookkeeping around it is cleared.
   always_ff @(posedge clk) begin
      if (wAccept && !rst) begin
         if (int'(wCnt_q) < HID_WORDS) begin
            hidW_q[HA_W'(wCnt_q)] <= s_data;
         end else begin
            finW_q[FA_W'(int'(wCnt_q) - HID_WORDS)] <= s_data;
         end
      end
   end

   assign hidRdAddr = HA_W'(int'(wt_rd_layer) * (FEATURES + 1) + int'(wt_rd_idx));

   always_ff @(posedge clk) begin
      if (rst) begin
         wtRdData_q <= '0;
         fwRdData_q <= '0;
      end else begin
         if (int'(wt_rd_layer) < LAYERS && int'(wt_rd_idx) <= FEATURES) begin
            wtRdData_q <= hidW_q[hidRdAddr];
         end else begin
            wtRdData_q <= '0;
         end
         if (int'(fw_rd_idx) < FIN_WORDS) begin
            fwRdData_q <= finW_q[FA_W'(fw_rd_idx)];
         end else begin
            fwRdData_q <= '0;
         end
      end
   end

   nn_sample_pingpong #(
      .FEATURES (FEATURES),
      .WORD_W   (WORD_W),
      .CNT_W    (CNT_W),
      .SW       (SW),
      .SIDX_W   (SIDX_W)
   ) uPingPong (
      .clk            (clk),
      .rst            (rst),
      .wrEn_i         (sAccept),
      .wrIdx_i        (wordIdx_q),
      .wrData_i       (s_data),
      .wrLast_i       (sLast),
      .wrSmpIdx_i     (smpCnt_q),
      .fillFull_o     (fillFull),
      .allEmptyNext_o (allEmptyNext),
      .smp_ready_i    (smp_ready),
      .smp_valid_o    (smp_valid),
      .smp_feat_o     (smp_feat),
      .smp_label_o    (smp_label),
      .smp_index_o    (smp_index)
   );

   assign s_ready        = sReady;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign err            = err_q;
   assign weights_loaded = wLoaded_q;
   assign wt_rd_data     = wtRdData_q;
   assign fw_rd_data     = fwRdData_q;

endmodule

// File: tb/tb_nn_stream_loader.sv
// Scoreboard bench for nn_stream_loader: directed weight/sample runs, samples checked by a negedge monitor.
// Follows NN_LOADER_LABEL_EN to size samples and predict smp_label.
module tb_nn_stream_loader;

   localparam int FEATURES = 15;
   localparam int LAYERS   = 10;
   localparam int CNT_W    = 16;
   localparam int WW       = 64;
   localparam int TOTAL_W  = LAYERS * (FEATURES + 1) + LAYERS + 1;
`ifdef NN_LOADER_LABEL_EN
   localparam int SW = FEATURES + 1;
`else
   localparam int SW = FEATURES;
`endif

   logic                   clk;
   logic                   rst;
   logic                   cfg_start;
   logic                   cfg_mode;
   logic [CNT_W-1:0]       cfg_count;
   logic [WW-1:0]          s_data;
   logic                   s_valid;
   logic                   s_ready;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic                   weights_loaded;
   logic [3:0]             wt_rd_layer;
   logic [3:0]             wt_rd_idx;
   logic [WW-1:0]          wt_rd_data;
   logic [3:0]             fw_rd_idx;
   logic [WW-1:0]          fw_rd_data;
   logic                   smp_valid;
   logic                   smp_ready;
   logic [FEATURES*WW-1:0] smp_feat;
   logic [WW-1:0]          smp_label;
   logic [CNT_W-1:0]       smp_index;

   nn_stream_loader #(
      .FEATURES (FEATURES),
      .LAYERS   (LAYERS),
      .WORD_W   (WW),
      .CNT_W    (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_start      (cfg_start),
      .cfg_mode       (cfg_mode),
      .cfg_count      (cfg_count),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .weights_loaded (weights_loaded),
      .wt_rd_layer    (wt_rd_layer),
      .wt_rd_idx      (wt_rd_idx),
      .wt_rd_data     (wt_rd_data),
      .fw_rd_idx      (fw_rd_idx),
      .fw_rd_data     (fw_rd_data),
      .smp_valid      (smp_valid),
      .smp_ready      (smp_ready),
      .smp_feat       (smp_feat),
      .smp_label      (smp_label),
      .smp_index      (smp_index)
   );

   typedef struct {
      logic [CNT_W-1:0]       idx;
      logic [FEATURES*WW-1:0] feat;
      logic [WW-1:0]          label;
   } exp_t;

   exp_t                   sbQ[$];
   exp_t                   monExp;
   int                     vectors;
   int                     miscompares;
   int                     runTag;
   int                     cyc;
   logic                   doneSeen;
   logic [FEATURES*WW-1:0] curFeat;
   logic [WW-1:0]          curLabel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WW-1:0] wordData(input int k);
      return {32'(runTag), 32'(k)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic startCfg(input logic mode, input int count);
      cfg_start = 1'b1;
      cfg_mode  = mode;
      cfg_count = CNT_W'(count);
      tick();
      cfg_start = 1'b0;
   endtask

   // Builds the expected sample as its words are accepted and queues it on the last one.
   task automatic recordWord(input int k);
      int n;
      int w;
      n = k / SW;
      w = k % SW;
      if (w < FEATURES) curFeat[w*WW +: WW] = wordData(k);
      else curLabel = wordData(k);
      if (w == SW - 1) begin
         monExp.idx  = CNT_W'(n);
         monExp.feat = curFeat;
`ifdef NN_LOADER_LABEL_EN
         monExp.label = curLabel;
`else
         monExp.label = '0;
`endif
         sbQ.push_back(monExp);
         curFeat = '0;
      end
   endtask

   // Streams sample words with s_valid held high, advancing only on accepted beats.
   task automatic applyStimulus(input int firstWord, input int nWords, input int budget, output int cycles);
      int  k;
      logic acc;
      k      = firstWord;
      cycles = 0;
      while (k < firstWord + nWords && cycles < budget) begin
         s_valid = 1'b1;
         s_data  = wordData(k);
         acc     = s_ready;
         tick();
         cycles++;
         if (acc) begin
            recordWord(k);
            k++;
         end
      end
      s_valid = 1'b0;
      if (k < firstWord + nWords) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL stream timeout: accepted %0d of %0d words", k - firstWord, nWords);
      end
   endtask

   task automatic loadWeights(input real base, input int nWords);
      startCfg(1'b0, 0);
      checkOutput("wload s_ready", 64'(s_ready), 64'd1);
      checkOutput("wload busy", 64'(busy), 64'd1);
      checkOutput("wload weights_loaded clear", 64'(weights_loaded), 64'd0);
      for (int i = 0; i < nWords; i++) begin
         s_valid = 1'b1;
         s_data  = $realtobits(base + real'(i));
         tick();
         if (i == TOTAL_W - 2) checkOutput("done before last word", 64'(done), 64'd0);
         if (i == TOTAL_W - 1) begin
            checkOutput("done after last word", 64'(done), 64'd1);
            checkOutput("weights_loaded set", 64'(weights_loaded), 64'd1);
            checkOutput("busy after wload", 64'(busy), 64'd0);
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic readCheck(input int layer, input int idx, input int fidx, input logic [WW-1:0] expW, input logic [WW-1:0] expF);
      wt_rd_layer = 4'(layer);
      wt_rd_idx   = 4'(idx);
      fw_rd_idx   = 4'(fidx);
      tick();
      checkOutput($sformatf("wt_rd L%0d I%0d", layer, idx), wt_rd_data, expW);
      checkOutput($sformatf("fw_rd I%0d", fidx), fw_rd_data, expF);
   endtask

   task automatic pulseReady();
      smp_ready = 1'b1;
      tick();
      smp_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && smp_valid && smp_ready) begin
         if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected sample: got index %0d expected none", smp_index);
         end else begin
            int bad;
            monExp = sbQ.pop_front();
            checkOutput("smp_index", 64'(smp_index), 64'(monExp.idx));
            checkOutput("smp_label", smp_label, monExp.label);
            bad = -1;
            for (int f = 0; f < FEATURES; f++) begin
               if (bad < 0 && smp_feat[f*WW +: WW] !== monExp.feat[f*WW +: WW]) bad = f;
            end
            vectors++;
            if (bad >= 0) begin
               miscompares++;
               $display("[TB] FAIL smp_feat[%0d] of sample %0d: got %h expected %h",
                        bad, monExp.idx, smp_feat[bad*WW +: WW], monExp.feat[bad*WW +: WW]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      runTag      = 0;
      curFeat     = '0;
      curLabel    = '0;
      rst         = 1'b1;
      cfg_start   = 1'b0;
      cfg_mode    = 1'b0;
      cfg_count   = '0;
      s_data      = '0;
      s_valid     = 1'b0;
      smp_ready   = 1'b0;
      wt_rd_layer = '0;
      wt_rd_idx   = '0;
      fw_rd_idx   = '0;
      tick();
      tick();

      checkOutput("reset s_ready", 64'(s_ready), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset err", 64'(err), 64'd0);
      checkOutput("reset weights_loaded", 64'(weights_loaded), 64'd0);
      checkOutput("reset smp_valid", 64'(smp_valid), 64'd0);
      checkOutput("reset smp_index", 64'(smp_index), 64'd0);
      checkOutput("reset wt_rd_data", wt_rd_data, 64'd0);
      checkOutput("reset fw_rd_data", fw_rd_data, 64'd0);
      rst = 1'b0;
      tick();

      startCfg(1'b1, 3);
      checkOutput("early sample err", 64'(err), 64'd1);
      checkOutput("early sample busy", 64'(busy), 64'd0);
      checkOutput("early sample s_ready", 64'(s_ready), 64'd0);
      tick();
      checkOutput("err one cycle", 64'(err), 64'd0);
      checkOutput("early sample s_ready later", 64'(s_ready), 64'd0);

      loadWeights(0.0, TOTAL_W);
      tick();
      checkOutput("done one cycle", 64'(done), 64'd0);
      readCheck(2, 15, 10, $realtobits(47.0), $realtobits(170.0));
      readCheck(9, 3, 0, $realtobits(147.0), $realtobits(160.0));
      readCheck(0, 15, 5, $realtobits(15.0), $realtobits(165.0));
      readCheck(10, 0, 11, 64'd0, 64'd0);

      startCfg(1'b1, 0);
      checkOutput("count0 done", 64'(done), 64'd1);
      checkOutput("count0 busy", 64'(busy), 64'd0);
      checkOutput("count0 s_ready", 64'(s_ready), 64'd0);
      tick();
      checkOutput("count0 done clears", 64'(done), 64'd0);
      checkOutput("count0 smp_valid", 64'(smp_valid), 64'd0);

      runTag = 1;
      startCfg(1'b1, 3);
      checkOutput("3smp busy", 64'(busy), 64'd1);
      applyStimulus(0, 2 * SW, 2 * SW + 8, cyc);
      checkOutput("3smp fill cycles", 64'(cyc), 64'(2 * SW));
      checkOutput("3smp s_ready both full", 64'(s_ready), 64'd0);
      checkOutput("3smp smp_valid", 64'(smp_valid), 64'd1);
      tick();
      checkOutput("3smp s_ready stalled", 64'(s_ready), 64'd0);
      pulseReady();
      checkOutput("3smp s_ready after drain", 64'(s_ready), 64'd1);
      applyStimulus(2 * SW, SW, SW + 8, cyc);
      checkOutput("3smp drain busy", 64'(busy), 64'd1);
      pulseReady();
      tick();
      pulseReady();
      checkOutput("3smp done", 64'(done), 64'd1);
      checkOutput("3smp idle", 64'(busy), 64'd0);
      checkOutput("3smp queue empty", 64'(sbQ.size()), 64'd0);
      tick();

      runTag = 2;
      startCfg(1'b1, 100);
      smp_ready = 1'b1;
      applyStimulus(0, 100 * SW, 100 * SW + 64, cyc);
      checkOutput("b2b cycles", 64'(cyc), 64'(100 * SW));
      doneSeen = 1'b0;
      for (int i = 0; i < 8 && !doneSeen; i++) begin
         tick();
         if (done) doneSeen = 1'b1;
      end
      checkOutput("b2b done seen", 64'(doneSeen), 64'd1);
      checkOutput("b2b queue empty", 64'(sbQ.size()), 64'd0);
      smp_ready = 1'b0;
      tick();

      loadWeights(5000.0, 50);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midreset weights_loaded", 64'(weights_loaded), 64'd0);
      checkOutput("midreset busy", 64'(busy), 64'd0);
      checkOutput("midreset s_ready", 64'(s_ready), 64'd0);
      tick();
      loadWeights(1000.0, TOTAL_W);
      tick();
      readCheck(2, 15, 10, $realtobits(1047.0), $realtobits(1170.0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
